data_mem_responder: RTL

- Data-memory responder for the RV32I datapath: the memory end of the datapath's load/store interface.
- Accepts one load or store per request. Inserts a fixed number of wait states, then returns a one-cycle `ready` pulse with read data or a fault flag.
- Handles byte, halfword and word accesses (little-endian), load sign/zero extension, and alignment and range checks.
- Sits between the datapath's ALU result / rs2 / `MemRW` outputs and the write-back mux.

---
 rtl/data_mem_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I load/store path: fixed wait states, then a
// one-cycle ready pulse carrying little-endian load data or a fault flag.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemRW,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        busy
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Rejects illegal types, misaligned halfword/word accesses and out-of-range words.
  function automatic logic access_fault(input logic [31:0] a, input logic st,
                                        input logic [2:0] f3);
    logic bad_type;
    logic misalign;
    logic out_range;
    bad_type  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                (st && (f3[2:1] == 2'b10));
    misalign  = ((f3[1:0] == 2'b01) && a[0]) ||
                ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
    out_range = ({2'b00, a[31:2]} >= DEPTH_WORDS);
    return bad_type || misalign || out_range;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IW+1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [2:0]     f3_q, f3_d;
  logic           fault_q, fault_d;

  logic [31:0]    mem_q [DEPTH_WORDS];
  logic [IW-1:0]  idx_s;
  logic [31:0]    rd_word_s;
  logic [3:0]     be_s;
  logic [31:0]    wd_s;
  logic [7:0]     byte_s;
  logic [15:0]    half_s;
  logic [31:0]    load_s;
  logic           resp_s;
  logic           commit_s;

  // State, wait counter and request capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic; inputs are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr[IW+1:0];
          wdata_d = wdata;
          we_d    = MemRW;
          f3_d    = funct3;
          fault_d = access_fault(addr, MemRW, funct3);
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign idx_s     = addr_q[IW+1:2];
  assign rd_word_s = mem_q[idx_s];
  assign resp_s    = (state_q == ST_RESP);
  assign commit_s  = resp_s && we_q && !fault_q;

  // Store lane enables and replicated store data.
  always_comb begin
    be_s = 4'b0000;
    wd_s = 32'h0000_0000;
    case (f3_q[1:0])
      2'b00: begin
        be_s = 4'b0001 << addr_q[1:0];
        wd_s = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_s = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_s = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be_s = 4'b1111;
        wd_s = wdata_q;
      end
      default: begin
        be_s = 4'b0000;
        wd_s = 32'h0000_0000;
      end
    endcase
  end

  // Storage array; deliberately has no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= wd_s[8*b +: 8];
        end
      end
    end
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    byte_s = 8'h00;
    load_s = 32'h0000_0000;
    case (addr_q[1:0])
      2'b00:   byte_s = rd_word_s[7:0];
      2'b01:   byte_s = rd_word_s[15:8];
      2'b10:   byte_s = rd_word_s[23:16];
      2'b11:   byte_s = rd_word_s[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_q[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (f3_q)
      3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_s = {{16{half_s[15]}}, half_s};
      3'b010:  load_s = rd_word_s;
      3'b100:  load_s = {24'h00_0000, byte_s};
      3'b101:  load_s = {16'h0000, half_s};
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Response outputs decode straight from state so reset clears them at once.
  assign ready = resp_s;
  assign fault = resp_s && fault_q;
  assign busy  = (state_q != ST_IDLE);
  assign rdata = (resp_s && !fault_q && !we_q) ? load_s : 32'h0000_0000;

endmodule
